// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: boot bubble, load-use,
// redirect and MDU freeze control, plus stall/flush statistics.
module pipe_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int BOOT_CYC    = 2,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_instr,
   input  logic             id_valid,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mdu_start,
   input  logic             mdu_done,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       pc_sel,
   output logic             ext_sig,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mdu_err
);

   localparam int BW = $clog2(BOOT_CYC + 1);
   localparam int TW = $clog2(MDU_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_MDU
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [BW-1:0]    r_boot_ctr;
   logic [TW-1:0]    r_tmo_ctr;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             r_mdu_err;

   logic [5:0] w_op;
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   logic       w_uses_rt;
   logic       w_load_use;
   logic       w_jump;
   logic       w_boot_done;
   logic       w_tmo_hit;
   logic       w_decode;
   logic       w_stall_inc;
   logic       w_flush_inc;
   logic       w_set_err;
   logic       w_unused;

   assign w_op     = id_instr[31:26];
   assign w_rs     = id_instr[25:21];
   assign w_rt     = id_instr[20:16];
   assign w_unused = &{1'b0, id_instr[15:0]};

   assign w_uses_rt = (w_op == 6'h00) || (w_op == 6'h04) ||
                      (w_op == 6'h05) || (w_op == 6'h2B);

   assign w_load_use = id_valid && ex_memread && (ex_rt != 5'd0) &&
                       ((ex_rt == w_rs) || (w_uses_rt && (ex_rt == w_rt)));

   assign w_jump = id_valid && ((w_op == 6'h02) || (w_op == 6'h03));

   assign w_boot_done = (r_boot_ctr == BW'(BOOT_CYC - 1));
   assign w_tmo_hit   = (r_tmo_ctr == TW'(MDU_TIMEOUT - 1));

   always_comb begin
      ext_sig = 1'b0;
      case (w_op)
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h23, 6'h2B, 6'h04, 6'h05: ext_sig = 1'b1;
         default:                    ext_sig = 1'b0;
      endcase
   end

   always_comb begin
      w_next      = r_state;
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      pc_sel      = 2'd0;
      w_decode    = 1'b0;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      w_set_err   = 1'b0;
      unique case (r_state)
         S_BOOT: begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (w_boot_done) w_next = S_RUN;
         end
         S_RUN: begin
            if (ex_branch_taken) begin
               pc_sel      = 2'd1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               w_flush_inc = 1'b1;
            end else if (mdu_start) begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_flush  = 1'b1;
               w_stall_inc = 1'b1;
               w_next      = S_MDU;
            end else begin
               w_decode = 1'b1;
            end
         end
         S_MDU: begin
            if (mdu_done || w_tmo_hit) begin
               // release cycle behaves as a normal RUN decode
               w_decode  = 1'b1;
               w_set_err = !mdu_done;
               w_next    = S_RUN;
            end else begin
               pc_we       = 1'b0;
               ifid_we     = 1'b0;
               idex_flush  = 1'b1;
               w_stall_inc = 1'b1;
            end
         end
         default: begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            w_next     = S_BOOT;
         end
      endcase
      if (w_decode) begin
         if (w_load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_flush  = 1'b1;
            w_stall_inc = 1'b1;
         end else if (w_jump) begin
            pc_sel      = 2'd2;
            ifid_flush  = 1'b1;
            w_flush_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_BOOT;
         r_boot_ctr  <= '0;
         r_tmo_ctr   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_mdu_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_BOOT && !w_boot_done)
            r_boot_ctr <= r_boot_ctr + 1'b1;
         if (r_state == S_MDU)
            r_tmo_ctr <= r_tmo_ctr + 1'b1;
         else
            r_tmo_ctr <= '0;
         if (w_stall_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush_inc && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
         if (w_set_err)
            r_mdu_err <= 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
   assign mdu_err   = r_mdu_err;

endmodule
